// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-select encoding, memory-stage FSM
// encoding and the load alignment rule used by the MEM stage.
package mips_pkg;

    localparam logic [2:0] LS_LW  = 3'd0;
    localparam logic [2:0] LS_LB  = 3'd1;
    localparam logic [2:0] LS_LBU = 3'd2;
    localparam logic [2:0] LS_LH  = 3'd3;
    localparam logic [2:0] LS_LHU = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Byte loads are never misaligned; encodings 5-7 behave as LW.
    function automatic logic load_misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
        logic mis;
        case (sel)
            LS_LB, LS_LBU: mis = 1'b0;
            LS_LH, LS_LHU: mis = addr_lo[0];
            default:       mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Little-endian lane selection and sign/zero extension of a bus read word.
// Purely combinational so the WB forwarding path can share it.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  load_sel_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend according to the load type.
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (load_sel_i)
            LS_LB:   data_o = {{24{byte_s[7]}}, byte_s};
            LS_LBU:  data_o = {24'h000000, byte_s};
            LS_LH:   data_o = {{16{half_s[15]}}, half_s};
            LS_LHU:  data_o = {16'h0000, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus controller: issues one req/ack transaction per load or
// store, stalls the pipeline until it completes, and returns extended load data.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic [31:0] exmem_alu_res,
    input  logic [31:0] exmem_aligned_rt_data,
    input  logic [3:0]  mem_byte_w_en,
    input  logic [2:0]  exmem_load_sel,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        mem_addr_err,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;
    logic [2:0]  sel_q, sel_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;

    logic        access_s;
    logic        mis_s;
    logic [7:0]  cnt_inc_s;
    logic [31:0] ext_s;

    // A set write flag wins over the read flag, so only pure loads are alignment-checked.
    assign access_s  = exmem_mem_r | exmem_mem_w;
    assign mis_s     = exmem_mem_r & ~exmem_mem_w & load_misaligned(exmem_load_sel, exmem_alu_res[1:0]);
    assign cnt_inc_s = cnt_q + 8'd1;

    load_extend u_load_extend (
        .rdata_i    (dbus_rdata),
        .addr_lo_i  (off_q),
        .load_sel_i (sel_q),
        .data_o     (ext_s)
    );

    // Next-state logic for the IDLE/REQ/DONE transaction sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        aerr_d      = 1'b0;
        berr_d      = 1'b0;
        sel_d       = sel_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s && !mis_s) begin
                    req_d     = 1'b1;
                    we_d      = exmem_mem_w;
                    addr_d    = {exmem_alu_res[31:2], 2'b00};
                    be_d      = exmem_mem_w ? mem_byte_w_en : 4'b1111;
                    wdata_d   = exmem_aligned_rt_data;
                    sel_d     = exmem_load_sel;
                    off_d     = exmem_alu_res[1:0];
                    is_load_d = ~exmem_mem_w;
                    cnt_d     = 8'd0;
                    state_d   = ST_REQ;
                end else if (mis_s) begin
                    aerr_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack on the final allowed cycle still completes normally.
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (is_load_q) begin
                        load_data_d = ext_s;
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s >= TIMEOUT_C) begin
                        req_d       = 1'b0;
                        berr_d      = 1'b1;
                        load_data_d = 32'h0000_0000;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, updated on the pipeline-register edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
            aerr_q      <= 1'b0;
            berr_q      <= 1'b0;
            sel_q       <= 3'd0;
            off_q       <= 2'd0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            aerr_q      <= aerr_d;
            berr_q      <= berr_d;
            sel_q       <= sel_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
        end
    end

    // Stall drops in DONE so the pipeline advances on the DONE->IDLE edge.
    assign mem_stall    = ((state_q == ST_IDLE) & access_s & ~mis_s) | (state_q == ST_REQ);
    assign dbus_req     = req_q;
    assign dbus_we      = we_q;
    assign dbus_addr    = addr_q;
    assign dbus_be      = be_q;
    assign dbus_wdata   = wdata_q;
    assign load_data    = load_data_q;
    assign mem_addr_err = aerr_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level expectation model
// drives per-cycle expected outputs, checked on the posedge (away from the negedge update).
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w;
    logic [31:0] alu, wdata_in;
    logic [3:0]  be_in;
    logic [2:0]  sel_in;
    logic [31:0] rdata;
    logic        ack;
    logic        dbus_req, dbus_we, mem_stall, mem_addr_err, bus_err;
    logic [31:0] dbus_addr, dbus_wdata, load_data;
    logic [3:0]  dbus_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .exmem_mem_r           (mem_r),
        .exmem_mem_w           (mem_w),
        .exmem_alu_res         (alu),
        .exmem_aligned_rt_data (wdata_in),
        .mem_byte_w_en         (be_in),
        .exmem_load_sel        (sel_in),
        .dbus_req              (dbus_req),
        .dbus_we               (dbus_we),
        .dbus_addr             (dbus_addr),
        .dbus_be               (dbus_be),
        .dbus_wdata            (dbus_wdata),
        .dbus_rdata            (rdata),
        .dbus_ack              (ack),
        .mem_stall             (mem_stall),
        .load_data             (load_data),
        .mem_addr_err          (mem_addr_err),
        .bus_err               (bus_err)
    );

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;
    int stall_base;
    logic chk_en = 1'b0;

    logic        exp_req, exp_we, exp_aerr, exp_berr, exp_stall;
    logic [31:0] exp_addr, exp_wdata, exp_load;
    logic [3:0]  exp_be;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Load result computed arithmetically from the selected lane.
    function automatic logic [31:0] model_ext(input logic [31:0] rd, input logic [31:0] addr, input logic [2:0] sel);
        logic [31:0] lane;
        logic [31:0] v;
        lane = addr % 32'd4;
        if (sel == 3'd1 || sel == 3'd2) begin
            v = (rd >> (32'd8 * lane)) & 32'h0000_00FF;
            if (sel == 3'd1 && v >= 32'd128) v = v - 32'd256;
        end else if (sel == 3'd3 || sel == 3'd4) begin
            v = (rd >> (32'd16 * (lane / 32'd2))) & 32'h0000_FFFF;
            if (sel == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic model_mis(input logic [2:0] sel, input logic [31:0] addr);
        if (sel == 3'd1 || sel == 3'd2) return 1'b0;
        if (sel == 3'd3 || sel == 3'd4) return (addr % 32'd2) != 32'd0;
        return (addr % 32'd4) != 32'd0;
    endfunction

    always @(posedge clk) begin
        if (chk_en) begin
            check32("dbus_req",     {31'd0, dbus_req},     {31'd0, exp_req});
            check32("dbus_we",      {31'd0, dbus_we},      {31'd0, exp_we});
            check32("dbus_addr",    dbus_addr,             exp_addr);
            check32("dbus_be",      {28'd0, dbus_be},      {28'd0, exp_be});
            check32("dbus_wdata",   dbus_wdata,            exp_wdata);
            check32("load_data",    load_data,             exp_load);
            check32("mem_addr_err", {31'd0, mem_addr_err}, {31'd0, exp_aerr});
            check32("bus_err",      {31'd0, bus_err},      {31'd0, exp_berr});
            check32("mem_stall",    {31'd0, mem_stall},    {31'd0, exp_stall});
            if (mem_stall) stall_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        exp_aerr = 1'b0;
        exp_berr = 1'b0;
    endtask

    task automatic idle_inputs();
        mem_r = 1'b0;
        mem_w = 1'b0;
    endtask

    // Present one instruction in EX/MEM; waits = REQ cycles before ack, -1 = never ack.
    task automatic access(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [2:0] sel, input logic [31:0] rd, input int waits);
        int  n;
        logic done;
        mem_r = r; mem_w = w; alu = addr; wdata_in = wd; be_in = be; sel_in = sel; ack = 1'b0;
        if (r && !w && model_mis(sel, addr)) begin
            exp_stall = 1'b0;
            step();
            exp_aerr = 1'b1;
            idle_inputs();
        end else begin
            exp_stall = 1'b1;
            step();
            exp_req = 1'b1; exp_we = w; exp_addr = addr & 32'hFFFF_FFFC;
            exp_be = w ? be : 4'hF; exp_wdata = wd;
            n = 0; done = 1'b0;
            while (!done) begin
                if (waits >= 0 && n == waits) begin ack = 1'b1; rdata = rd; end
                else begin ack = 1'b0; rdata = ~rd; end
                step();
                ack = 1'b0;
                n++;
                if (waits >= 0 && n == waits + 1) begin
                    done = 1'b1; exp_req = 1'b0; exp_stall = 1'b0;
                    if (!w) exp_load = model_ext(rd, addr, sel);
                end else if (n == TO) begin
                    done = 1'b1; exp_req = 1'b0; exp_stall = 1'b0; exp_berr = 1'b1; exp_load = 32'd0;
                end
            end
            // DONE: the same instruction is still presented and must not re-issue
            step();
            idle_inputs();
            exp_stall = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; idle_inputs(); alu = 32'd0; wdata_in = 32'd0; be_in = 4'd0; sel_in = 3'd0;
        rdata = 32'd0; ack = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0;
        exp_load = 32'd0; exp_aerr = 1'b0; exp_berr = 1'b0; exp_stall = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check32("rst_req",   {31'd0, dbus_req}, 32'd0);
        check32("rst_load",  load_data, 32'd0);
        check32("rst_addr",  dbus_addr, 32'd0);
        check32("rst_stall", {31'd0, mem_stall}, 32'd0);
        reset = 1'b0;
        step();

        stall_base = stall_cnt;
        access(1'b1, 1'b0, 32'h103, 32'd0, 4'd0, 3'd1, 32'h80FF_FF7F, 0);
        check32("lb_lit", load_data, 32'hFFFF_FF80);
        check32("lb_stall_cycles", stall_cnt - stall_base, 32'd2);

        access(1'b1, 1'b0, 32'h102, 32'd0, 4'd0, 3'd4, 32'h8001_1234, 0);
        check32("lhu_lit", load_data, 32'h0000_8001);
        step();
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'd0, 3'd3, 32'h8001_1234, 0);
        check32("lh_lit", load_data, 32'h0000_1234);

        step();
        stall_base = stall_cnt;
        access(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b1111, 3'd0, 32'h0BAD_0BAD, 3);
        check32("sw_load_kept", load_data, 32'h0000_1234);
        check32("sw_stall_cycles", stall_cnt - stall_base, 32'd5);
        check32("sw_addr_lit", dbus_addr, 32'h0000_0200);

        step();
        stall_base = stall_cnt;
        access(1'b1, 1'b0, 32'h202, 32'd0, 4'd0, 3'd0, 32'h1111_1111, 0);
        check32("lw_mis_aerr", {31'd0, mem_addr_err}, 32'd1);
        step();
        check32("lw_mis_stall", stall_cnt - stall_base, 32'd0);

        access(1'b1, 1'b1, 32'h203, 32'h1122_3344, 4'b1000, 3'd0, 32'd0, 1);
        step();
        access(1'b1, 1'b0, 32'h101, 32'd0, 4'd0, 3'd2, 32'h1234_F600, 1);
        check32("lbu_lit", load_data, 32'h0000_00F6);
        access(1'b1, 1'b0, 32'h204, 32'd0, 4'd0, 3'd0, 32'hCAFE_F00D, 2);
        check32("lw_lit", load_data, 32'hCAFE_F00D);

        step();
        ack = 1'b1; rdata = 32'hFFFF_FFFF;
        step();
        ack = 1'b0;
        step();
        check32("idle_ack_ignored", load_data, 32'hCAFE_F00D);

        stall_base = stall_cnt;
        access(1'b1, 1'b0, 32'h300, 32'd0, 4'd0, 3'd0, 32'h7777_7777, -1);
        check32("timeout_load", load_data, 32'd0);
        check32("timeout_stall_cycles", stall_cnt - stall_base, 32'd5);

        access(1'b1, 1'b0, 32'h104, 32'd0, 4'd0, 3'd0, 32'h55AA_55AA, 0);
        step();
        mem_r = 1'b1; alu = 32'h108; sel_in = 3'd0; wdata_in = 32'h0000_0042;
        exp_stall = 1'b1;
        step();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h108; exp_be = 4'hF; exp_wdata = 32'h0000_0042;
        reset = 1'b1;
        step();
        exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0;
        exp_load = 32'd0; exp_stall = 1'b0;
        idle_inputs();
        reset = 1'b0;
        check32("rst_mid_req",  {31'd0, dbus_req}, 32'd0);
        check32("rst_mid_load", load_data, 32'd0);
        step();
        ack = 1'b1; rdata = 32'h1234_5678;
        step();
        ack = 1'b0;
        step();
        check32("late_ack_ignored", load_data, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-access controller of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline-register outputs (memory read/write flags, ALU address, aligned store data, byte enables, load select). Runs a req/ack transaction on the data bus, holds the pipeline stalled until it completes, and returns a sign/zero-extended load result to the MEM/WB register. Detects misaligned loads and bus timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in REQ waiting for dbus_ack before aborting (1..255).

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, same edge as the pipeline registers.
- reset  in  1  synchronous, active-high.
- exmem_mem_r  in  1  load in MEM.
- exmem_mem_w  in  1  store in MEM.
- exmem_alu_res  in  32  effective address.
- exmem_aligned_rt_data  in  32  store data, already lane-shifted.
- mem_byte_w_en  in  4  store byte enables, bit i = byte lane i.
- exmem_load_sel  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 decode as LW.
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word address (addr[1:0] forced 0).
- dbus_be  out  4  byte enables; 4'b1111 for reads.
- dbus_wdata  out  32  write data.
- dbus_rdata  in  32  read data, valid with dbus_ack.
- dbus_ack  in  1  one-cycle completion strobe.
- mem_stall  out  1  to hazard unit; drives cu_stall for the IF..EX/MEM registers.
- load_data  out  32  extended load result, registered.
- mem_addr_err  out  1  misaligned-load pulse, 1 cycle.
- bus_err  out  1  timeout pulse, 1 cycle.

## Operation
- State machine IDLE, REQ, DONE. Register reset values: state IDLE, every output 0, timeout counter 0.
- access = exmem_mem_r | exmem_mem_w. If both are set, it is a store.
- Misalignment applies to loads only: LW/default with addr[1:0]≠0; LH/LHU with addr[0]≠0. Stores are trusted (byte enables come from upstream).
- IDLE:
  - access and aligned: latch addr/we/be/wdata onto the bus outputs, dbus_req←1, counter←0, go to REQ.
  - Misaligned load: mem_addr_err←1 for one cycle, no bus request, stay IDLE.
- REQ:
  - dbus_ack=1: dbus_req←0. For a load, capture the extracted lane of dbus_rdata into load_data. Go to DONE.
  - Otherwise counter+1. If the counter reaches TIMEOUT: dbus_req←0, bus_err←1, load_data←0, go to DONE.
- DONE: go to IDLE unconditionally. Never re-issue, even though the same instruction is still in EX/MEM during this cycle.
- Load extraction (little-endian, lane = addr[1:0]):
  - LB/LBU use byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU use half addr[1] (bits 15:0 or 31:16), sign- or zero-extended.
  - LW passes through unchanged.
- mem_stall is combinational:
  - 1 when (IDLE & access & not misaligned) or REQ.
  - 0 in DONE, so the pipeline advances on the DONE→IDLE edge.

## Timing
- Minimum access: issue edge → REQ. With ack at the first REQ edge: DONE, load_data valid during DONE, IDLE on the next edge. That gives 2 stall cycles + 1 release cycle.
- Each extra wait cycle before ack adds one stall cycle.
- Bus outputs stay stable throughout REQ.
- dbus_ack is ignored outside REQ.
- Reset mid-transaction: next edge forces IDLE and dbus_req=0. The outstanding bus access is abandoned, and the bus must drop it on seeing req low.
- Back-to-back accesses: the second access issues from IDLE on the edge after DONE. No bus request is ever issued from DONE.
- Timeout and ack in the same REQ cycle: ack wins, no bus_err.

## Structure
- Shared package `mips_pkg`:
  - load_sel encoding constants: LS_LW, LS_LB, LS_LBU, LS_LH, LS_LHU.
  - FSM state encoding.
- One sub-module, `load_extend`: combinational lane selection and extension (rdata, addr[1:0], load_sel → 32-bit). It is reused by the WB forwarding path.

## Test plan
- LB at addr 0x103, rdata 0x80FF_FF7F, ack first REQ cycle → load_data 0xFFFF_FF80, mem_stall high exactly 2 cycles.
- LHU at addr 0x102, rdata 0x8001_1234 → load_data 0x0000_8001. LH at 0x100 with the same rdata → 0x0000_1234.
- SW at 0x200, data 0xDEADBEEF, be 4'b1111, ack after 3 wait cycles → dbus_we=1, dbus_addr 0x200, stall 5 cycles, load_data unchanged.
- LW at 0x202 → mem_addr_err one cycle, dbus_req never asserted, mem_stall 0.
- Read with no ack, TIMEOUT=4 → bus_err pulses on the 4th REQ cycle, load_data 0, FSM returns to IDLE.
- reset asserted in REQ → next edge IDLE, dbus_req 0, all outputs 0. A later ack is ignored.
